// File: rtl/led_multi_ctrl.sv
// Multi-channel LED controller with a shared 1 us / 1 ms timebase.
// Ports: clk, reset (sync, active-high); cfg_valid/cfg_ready handshake
//   carrying cfg_ch, cfg_mode, cfg_period, cfg_duty; us_tick, ms_tick
//   timebase pulses; led_out registered LED drive (1 = lit).
module led_multi_ctrl #(
   parameter int CLK_PER_US = 24,
   parameter int US_PER_MS  = 1000,
   parameter int NUM_CH     = 4,
   parameter int PERIOD_W   = 10,
   parameter int PWM_W      = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [3:0]          cfg_ch,
   input  logic [1:0]          cfg_mode,
   input  logic [PERIOD_W-1:0] cfg_period,
   input  logic [PWM_W-1:0]    cfg_duty,
   output logic                us_tick,
   output logic                ms_tick,
   output logic [NUM_CH-1:0]   led_out
);

   localparam int US_W = $clog2(CLK_PER_US);
   localparam int MS_W = $clog2(US_PER_MS);
   localparam logic [US_W-1:0] US_LAST = US_W'(CLK_PER_US - 1);
   localparam logic [MS_W-1:0] MS_LAST = MS_W'(US_PER_MS - 1);

   typedef enum logic [1:0] {
      M_OFF   = 2'b00,
      M_ON    = 2'b01,
      M_BLINK = 2'b10,
      M_PWM   = 2'b11
   } mode_t;

   typedef enum logic {
      S_IDLE,
      S_PEND
   } cfg_state_t;

   logic [US_W-1:0]     us_cnt;
   logic [MS_W-1:0]     ms_cnt;
   logic [PWM_W-1:0]    pwm_cnt;
   logic [PWM_W-1:0]    pwm_nxt;
   cfg_state_t          state_q;
   cfg_state_t          state_d;
   logic                accept;
   logic                apply;

   logic [3:0]          sh_ch;
   mode_t               sh_mode;
   logic [PERIOD_W-1:0] sh_period;
   logic [PWM_W-1:0]    sh_duty;

   mode_t               mode_q   [NUM_CH];
   mode_t               mode_d   [NUM_CH];
   logic [PERIOD_W-1:0] period_q [NUM_CH];
   logic [PERIOD_W-1:0] period_d [NUM_CH];
   logic [PWM_W-1:0]    duty_q   [NUM_CH];
   logic [PWM_W-1:0]    duty_d   [NUM_CH];
   logic [PERIOD_W-1:0] bcnt_q   [NUM_CH];
   logic [PERIOD_W-1:0] bcnt_d   [NUM_CH];
   logic [NUM_CH-1:0]   phase_q;
   logic [NUM_CH-1:0]   phase_d;
   logic [NUM_CH-1:0]   led_d;

   // A zero half-period behaves like one ms.
   function automatic logic [PERIOD_W-1:0] blink_lim(
      input logic [PERIOD_W-1:0] p
   );
      return (p == '0) ? '0 : p - 1'b1;
   endfunction

   assign us_tick   = (us_cnt == US_LAST);
   assign ms_tick   = us_tick && (ms_cnt == MS_LAST);
   assign cfg_ready = (state_q == S_IDLE);
   assign accept    = cfg_valid && cfg_ready;
   // Pending is only set after the accept edge, so a write accepted
   // on an ms_tick waits for the following one.
   assign apply     = (state_q == S_PEND) && ms_tick;
   assign pwm_nxt   = us_tick ? pwm_cnt + 1'b1 : pwm_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         us_cnt  <= '0;
         ms_cnt  <= '0;
         pwm_cnt <= '0;
      end else begin
         us_cnt  <= us_tick ? '0 : us_cnt + 1'b1;
         if (us_tick)
            ms_cnt <= (ms_cnt == MS_LAST) ? '0 : ms_cnt + 1'b1;
         pwm_cnt <= pwm_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (accept)  state_d = S_PEND;
         S_PEND: if (ms_tick) state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sh_ch     <= '0;
         sh_mode   <= M_OFF;
         sh_period <= '0;
         sh_duty   <= '0;
      end else if (accept) begin
         sh_ch     <= cfg_ch;
         sh_mode   <= mode_t'(cfg_mode);
         sh_period <= cfg_period;
         sh_duty   <= cfg_duty;
      end
   end

   // Next channel state is computed here so led_out can be registered
   // from it and show a new mode/phase in the cycle after the tick.
   always_comb begin
      phase_d = phase_q;
      led_d   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         mode_d[i]   = mode_q[i];
         period_d[i] = period_q[i];
         duty_d[i]   = duty_q[i];
         bcnt_d[i]   = bcnt_q[i];
         if (mode_q[i] == M_BLINK && ms_tick) begin
            if (bcnt_q[i] == blink_lim(period_q[i])) begin
               phase_d[i] = ~phase_q[i];
               bcnt_d[i]  = '0;
            end else begin
               bcnt_d[i]  = bcnt_q[i] + 1'b1;
            end
         end
         if (apply && sh_ch == 4'(i)) begin
            mode_d[i]   = sh_mode;
            period_d[i] = sh_period;
            duty_d[i]   = sh_duty;
            bcnt_d[i]   = '0;
            if (sh_mode == M_BLINK)
               phase_d[i] = 1'b1;
         end
         unique case (mode_d[i])
            M_OFF:   led_d[i] = 1'b0;
            M_ON:    led_d[i] = 1'b1;
            M_BLINK: led_d[i] = phase_d[i];
            M_PWM:   led_d[i] = (pwm_nxt < duty_d[i]);
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            mode_q[i]   <= M_OFF;
            period_q[i] <= '0;
            duty_q[i]   <= '0;
            bcnt_q[i]   <= '0;
         end
         phase_q <= '0;
         led_out <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            mode_q[i]   <= mode_d[i];
            period_q[i] <= period_d[i];
            duty_q[i]   <= duty_d[i];
            bcnt_q[i]   <= bcnt_d[i];
         end
         phase_q <= phase_d;
         led_out <= led_d;
      end
   end

endmodule

// File: tb/tb_led_multi_ctrl.sv
// Directed bench for led_multi_ctrl with a small timebase.
// Cycle 1 is the first cycle after reset is released.
module tb_led_multi_ctrl;

   localparam int CPU = 4;
   localparam int UPM = 5;
   localparam int NCH = 4;
   localparam int PW  = 4;
   localparam int DW  = 3;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           cfg_valid = 1'b0;
   logic           cfg_ready;
   logic [3:0]     cfg_ch = '0;
   logic [1:0]     cfg_mode = '0;
   logic [PW-1:0]  cfg_period = '0;
   logic [DW-1:0]  cfg_duty = '0;
   logic           us_tick;
   logic           ms_tick;
   logic [NCH-1:0] led_out;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   led_multi_ctrl #(
      .CLK_PER_US(CPU),
      .US_PER_MS (UPM),
      .NUM_CH    (NCH),
      .PERIOD_W  (PW),
      .PWM_W     (DW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_mode  (cfg_mode),
      .cfg_period(cfg_period),
      .cfg_duty  (cfg_duty),
      .us_tick   (us_tick),
      .ms_tick   (ms_tick),
      .led_out   (led_out)
   );

   typedef struct {
      int         cyc;
      logic       valid;
      logic [3:0] ch;
      logic [1:0] mode;
      logic [3:0] period;
      logic [2:0] duty;
      logic       us;
      logic       ms;
      logic       rdy;
      logic [3:0] led;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h",
                  name, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      cfg_valid = 1'b0;
   endtask

   task automatic go(input int n);
      while (cyc < n) tick();
   endtask

   task automatic wr(input logic [3:0] ch, input logic [1:0] mode,
                     input logic [3:0] per, input logic [2:0] duty);
      cfg_valid  = 1'b1;
      cfg_ch     = ch;
      cfg_mode   = mode;
      cfg_period = per;
      cfg_duty   = duty;
   endtask

   task automatic count_hi(input int b, input int n, output int hits);
      hits = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         hits += int'(led_out[b]);
         tick();
      end
   endtask

   int bc[5];
   logic bl[5];
   int hits;

   initial begin
      //          cyc v  ch  mode   per  duty us ms rdy led
      tbl.push_back('{1,  0, 0, 2'b00, 0, 0, 0, 0, 1, 4'b0000});
      tbl.push_back('{3,  1, 1, 2'b01, 0, 0, 0, 0, 1, 4'b0000});
      tbl.push_back('{4,  0, 0, 2'b00, 0, 0, 1, 0, 0, 4'b0000});
      tbl.push_back('{8,  0, 0, 2'b00, 0, 0, 1, 0, 0, 4'b0000});
      tbl.push_back('{10, 1, 3, 2'b01, 0, 0, 0, 0, 0, 4'b0000});
      tbl.push_back('{19, 0, 0, 2'b00, 0, 0, 0, 0, 0, 4'b0000});
      tbl.push_back('{20, 0, 0, 2'b00, 0, 0, 1, 1, 0, 4'b0000});
      tbl.push_back('{21, 0, 0, 2'b00, 0, 0, 0, 0, 1, 4'b0010});
      tbl.push_back('{40, 1, 3, 2'b01, 0, 0, 1, 1, 1, 4'b0010});
      tbl.push_back('{41, 0, 0, 2'b00, 0, 0, 0, 0, 0, 4'b0010});
      tbl.push_back('{60, 0, 0, 2'b00, 0, 0, 1, 1, 0, 4'b0010});
      tbl.push_back('{61, 0, 0, 2'b00, 0, 0, 0, 0, 1, 4'b1010});

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      cyc = 1;

      foreach (tbl[j]) begin
         go(tbl[j].cyc);
         if (tbl[j].valid)
            wr(tbl[j].ch, tbl[j].mode, tbl[j].period, tbl[j].duty);
         @(negedge clk);
         chk("us_tick", 32'(us_tick), 32'(tbl[j].us));
         chk("ms_tick", 32'(ms_tick), 32'(tbl[j].ms));
         chk("cfg_ready", 32'(cfg_ready), 32'(tbl[j].rdy));
         chk("led_out", 32'(led_out), 32'(tbl[j].led));
      end

      // ch0 blink, half-period 2 ms = 40 cycles
      go(62);
      wr(4'd0, 2'b10, 4'd2, 3'd0);
      @(negedge clk);
      chk("blink2_ready", 32'(cfg_ready), 32'd1);
      go(80);
      @(negedge clk);
      chk("blink2_pre", 32'(led_out[0]), 32'd0);
      bc = '{81, 120, 121, 160, 161};
      bl = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 5; k++) begin
         go(bc[k]);
         @(negedge clk);
         chk("blink2", 32'(led_out[0]), 32'(bl[k]));
      end

      // period 0 behaves as 1 ms = 20 cycles
      go(162);
      wr(4'd0, 2'b10, 4'd0, 3'd0);
      bc = '{181, 200, 201, 220, 221};
      bl = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 5; k++) begin
         go(bc[k]);
         @(negedge clk);
         chk("blink0", 32'(led_out[0]), 32'(bl[k]));
      end

      // ch2 PWM, counted over one 32-cycle frame
      go(222);
      wr(4'd2, 2'b11, 4'd0, 3'd3);
      go(241);
      count_hi(2, 32, hits);
      chk("pwm_duty3", 32'(hits), 32'd12);
      wr(4'd2, 2'b11, 4'd0, 3'd0);
      go(281);
      count_hi(2, 32, hits);
      chk("pwm_duty0", 32'(hits), 32'd0);
      wr(4'd2, 2'b11, 4'd0, 3'd7);
      go(321);
      count_hi(2, 32, hits);
      chk("pwm_duty7", 32'(hits), 32'd28);

      // out-of-range channel: handshake only
      go(353);
      wr(4'd5, 2'b00, 4'd0, 3'd0);
      go(354);
      @(negedge clk);
      chk("ch5_busy", 32'(cfg_ready), 32'd0);
      go(361);
      @(negedge clk);
      chk("ch5_ready", 32'(cfg_ready), 32'd1);
      chk("ch5_led", 32'(led_out & 4'b1011), 32'(4'b1010));

      // reset with a write pending and ch0 blinking
      go(362);
      wr(4'd1, 2'b01, 4'd0, 3'd0);
      go(370);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_led", 32'(led_out), 32'd0);
      chk("rst_ready", 32'(cfg_ready), 32'd1);
      chk("rst_us", 32'(us_tick), 32'd0);
      go(374);
      @(negedge clk);
      chk("rst_us4", 32'(us_tick), 32'd1);
      go(380);
      @(negedge clk);
      chk("rst_ready2", 32'(cfg_ready), 32'd1);
      go(390);
      @(negedge clk);
      chk("rst_ms20", 32'(ms_tick), 32'd1);
      go(391);
      @(negedge clk);
      chk("rst_nowrite", 32'(led_out), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
